// File: rtl/video_pll_pkg.sv
// Shared definitions for the video PLL reset controller.
//   state_e        : controller state encoding (also exported on state_dbg)
//   DEF_*          : default parameter values for video_pll_reset_ctrl
//   LOCK_LOSS_W    : width of the saturating lock-loss counter
package video_pll_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE_CHK = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_e;

  localparam int DEF_RST_PULSE_CYCLES    = 50;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_SYNC_STAGES         = 2;

  localparam int LOCK_LOSS_W = 8;

endpackage

// File: rtl/video_pll_reset_ctrl_sync_bit.sv
// Single-bit multi-flop synchroniser.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : d delayed by STAGES clk cycles, safe to use in the clk domain
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/video_pll_reset_ctrl.sv
// Video PLL reset / lock-qualification controller (refclk domain).
// Pulses the PLL reset, waits for a synchronised lock, qualifies it as
// stable, then releases the video reset. Lock loss in RUN restarts the
// sequence; MAX_RETRIES consecutive timeouts park the block in FAULT.
//   refclk          : reference clock (only clock)
//   rst             : synchronous active-high reset
//   pll_locked      : PLL lock, asynchronous to refclk
//   force_relock    : single-cycle request to restart bring-up
//   pll_rst         : reset to the PLL
//   video_rst       : video-domain reset request, low only in RUN
//   ready           : high only in RUN
//   fault           : high only in FAULT
//   retry_count     : lock timeouts in the current bring-up
//   lock_loss_count : lock losses seen in RUN, saturating
//   state_dbg       : current controller state
module video_pll_reset_ctrl
  import video_pll_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  localparam int RETRY_W            = $clog2(MAX_RETRIES + 1)
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   force_relock,
  output logic                   pll_rst,
  output logic                   video_rst,
  output logic                   ready,
  output logic                   fault,
  output logic [RETRY_W-1:0]     retry_count,
  output logic [LOCK_LOSS_W-1:0] lock_loss_count,
  output state_e                 state_dbg
);

  localparam int PULSE_W = $clog2(RST_PULSE_CYCLES) + 1;
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES) + 1;

  logic lk;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  state_e                 state, state_nx;
  logic [PULSE_W-1:0]     pulse_cnt, pulse_nx;
  logic [TMO_W-1:0]       tmo_cnt, tmo_nx, tmo_inc;
  logic [STB_W-1:0]       stable_cnt, stable_nx, stable_inc;
  logic [RETRY_W-1:0]     retry_nx, retry_inc;
  logic [LOCK_LOSS_W-1:0] loss_nx;
  logic                   tmo_hit;
  logic                   timeout;

  assign tmo_inc    = tmo_cnt + 1'b1;
  assign tmo_hit    = (tmo_inc == TMO_W'(LOCK_TIMEOUT_CYCLES));
  assign stable_inc = stable_cnt + 1'b1;
  assign retry_inc  = retry_count + 1'b1;

  always_comb begin
    state_nx  = state;
    pulse_nx  = pulse_cnt;
    tmo_nx    = tmo_cnt;
    stable_nx = stable_cnt;
    retry_nx  = retry_count;
    loss_nx   = lock_loss_count;
    timeout   = 1'b0;

    case (state)
      ST_PLL_RST: begin
        if (pulse_cnt == PULSE_W'(RST_PULSE_CYCLES - 1)) begin
          state_nx = ST_WAIT_LOCK;
          tmo_nx   = '0;
        end else begin
          pulse_nx = pulse_cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        tmo_nx = tmo_inc;
        if (tmo_hit) begin
          timeout = 1'b1;
        end else if (lk) begin
          state_nx  = ST_STABLE_CHK;
          stable_nx = '0;
        end
      end
      ST_STABLE_CHK: begin
        // Timeout budget keeps running so a glitching lock still expires.
        tmo_nx = tmo_inc;
        if (tmo_hit) begin
          timeout = 1'b1;
        end else if (!lk) begin
          state_nx = ST_WAIT_LOCK;
        end else if (stable_inc >= STB_W'(LOCK_STABLE_CYCLES - 1)) begin
          // The lk cycle that moved us out of WAIT_LOCK is the first of the
          // consecutive locked cycles, hence the -1.
          state_nx = ST_RUN;
          retry_nx = '0;
        end else begin
          stable_nx = stable_inc;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_nx = ST_PLL_RST;
          pulse_nx = '0;
          if (lock_loss_count != '1) begin
            loss_nx = lock_loss_count + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        state_nx = ST_FAULT;
      end
      default: begin
        state_nx = ST_PLL_RST;
        pulse_nx = '0;
      end
    endcase

    if (timeout) begin
      retry_nx = retry_inc;
      pulse_nx = '0;
      state_nx = (retry_inc == RETRY_W'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
    end

    // Relock request overrides every transition, including a lock-loss count.
    if (force_relock) begin
      state_nx = ST_PLL_RST;
      pulse_nx = '0;
      retry_nx = '0;
      loss_nx  = lock_loss_count;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= ST_PLL_RST;
      pulse_cnt       <= '0;
      tmo_cnt         <= '0;
      stable_cnt      <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      video_rst       <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_nx;
      pulse_cnt       <= pulse_nx;
      tmo_cnt         <= tmo_nx;
      stable_cnt      <= stable_nx;
      retry_count     <= retry_nx;
      lock_loss_count <= loss_nx;
      // Outputs decoded from the next state so they switch with the state.
      pll_rst         <= (state_nx == ST_PLL_RST) || (state_nx == ST_FAULT);
      video_rst       <= (state_nx != ST_RUN);
      ready           <= (state_nx == ST_RUN);
      fault           <= (state_nx == ST_FAULT);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_video_pll_reset_ctrl.sv
// Bench for video_pll_reset_ctrl with a small timing configuration.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// the last edge of each step.
module tb_video_pll_reset_ctrl;
  import video_pll_pkg::*;

  localparam int RPC = 4;
  localparam int LTC = 40;
  localparam int LSC = 8;
  localparam int MR  = 2;
  localparam int SS  = 2;
  localparam int RW  = $clog2(MR + 1);
  localparam int EW  = 4 + RW + LOCK_LOSS_W + 3;

  // ---------------- clock / reset ----------------
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic force_relock = 1'b0;
  logic pll_rst, video_rst, ready, fault;
  logic [RW-1:0] retry_count;
  logic [LOCK_LOSS_W-1:0] lock_loss_count;
  state_e state_dbg;

  always #5 refclk = ~refclk;

  video_pll_reset_ctrl #(
    .RST_PULSE_CYCLES    (RPC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .LOCK_STABLE_CYCLES  (LSC),
    .MAX_RETRIES         (MR),
    .SYNC_STAGES         (SS)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .force_relock    (force_relock),
    .pll_rst         (pll_rst),
    .video_rst       (video_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .state_dbg       (state_dbg)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic          r;
    logic          locked;
    logic          frc;
    int            n;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [EW-1:0] mk(logic pr, logic vr, logic rd, logic ft,
                                       int retry, int loss, state_e st);
    logic [2:0] s;
    s = st;
    return {pr, vr, rd, ft, RW'(retry), LOCK_LOSS_W'(loss), s};
  endfunction

  task automatic add(logic r, logic locked, logic frc, int n, logic [EW-1:0] exp);
    vec_t v;
    v.r = r;
    v.locked = locked;
    v.frc = frc;
    v.n = n;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(string name);
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    logic [2:0] s;
    s = state_dbg;
    got = {pll_rst, video_rst, ready, fault, retry_count, lock_loss_count, s};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got === e) n_pass++;
      else $display("FAIL %s: got {pr,vr,rdy,flt,retry,loss,st}=%h required %h",
                    name, got, e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(string name, logic r, logic locked, logic frc, int n,
                      logic [EW-1:0] exp);
    rst = r;
    pll_locked = locked;
    force_relock = frc;
    exp_q.push_back(exp);
    repeat (n) @(posedge refclk);
    #1;
    check(name);
  endtask

  initial begin
    int sat;
    // Bring-up: pll_rst high 4 cycles, lock 10 cycles after, ready 2+8 later.
    add(1, 0, 0,  2, mk(1, 1, 0, 0, 0, 0, ST_PLL_RST));
    add(0, 0, 0,  3, mk(1, 1, 0, 0, 0, 0, ST_PLL_RST));
    add(0, 0, 0,  1, mk(0, 1, 0, 0, 0, 0, ST_WAIT_LOCK));
    add(0, 0, 0, 10, mk(0, 1, 0, 0, 0, 0, ST_WAIT_LOCK));
    add(0, 1, 0,  2, mk(0, 1, 0, 0, 0, 0, ST_WAIT_LOCK));
    add(0, 1, 0,  7, mk(0, 1, 0, 0, 0, 0, ST_STABLE_CHK));
    add(0, 1, 0,  1, mk(0, 0, 1, 0, 0, 0, ST_RUN));
    // Lock loss in RUN: seen 2+1 cycles later, then a fresh pulse.
    add(0, 0, 0,  2, mk(0, 0, 1, 0, 0, 0, ST_RUN));
    add(0, 0, 0,  1, mk(1, 1, 0, 0, 0, 1, ST_PLL_RST));
    add(0, 0, 0,  3, mk(1, 1, 0, 0, 0, 1, ST_PLL_RST));
    add(0, 0, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_WAIT_LOCK));
    // One-cycle lock glitch at stable count 5: back to WAIT_LOCK, no pulse.
    add(0, 1, 0,  6, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(0, 0, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_WAIT_LOCK));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(0, 1, 0,  6, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(0, 1, 0,  1, mk(0, 0, 1, 0, 0, 1, ST_RUN));
    // Relock, then lock never arrives: two timeouts lead to FAULT.
    add(0, 0, 1,  1, mk(1, 1, 0, 0, 0, 1, ST_PLL_RST));
    add(0, 0, 0,  3, mk(1, 1, 0, 0, 0, 1, ST_PLL_RST));
    add(0, 0, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_WAIT_LOCK));
    add(0, 0, 0, 39, mk(0, 1, 0, 0, 0, 1, ST_WAIT_LOCK));
    add(0, 0, 0,  1, mk(1, 1, 0, 0, 1, 1, ST_PLL_RST));
    add(0, 0, 0,  3, mk(1, 1, 0, 0, 1, 1, ST_PLL_RST));
    add(0, 0, 0,  1, mk(0, 1, 0, 0, 1, 1, ST_WAIT_LOCK));
    add(0, 0, 0, 39, mk(0, 1, 0, 0, 1, 1, ST_WAIT_LOCK));
    add(0, 0, 0,  1, mk(1, 1, 0, 1, 2, 1, ST_FAULT));
    add(0, 1, 0, 20, mk(1, 1, 0, 1, 2, 1, ST_FAULT));
    // force_relock out of FAULT, normal bring-up with lock already present.
    add(0, 1, 1,  1, mk(1, 1, 0, 0, 0, 1, ST_PLL_RST));
    add(0, 1, 0,  3, mk(1, 1, 0, 0, 0, 1, ST_PLL_RST));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_WAIT_LOCK));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(0, 1, 0,  6, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(0, 1, 0,  1, mk(0, 0, 1, 0, 0, 1, ST_RUN));
    // rst together with force_relock while in STABLE_CHK.
    add(0, 1, 1,  1, mk(1, 1, 0, 0, 0, 1, ST_PLL_RST));
    add(0, 1, 0,  4, mk(0, 1, 0, 0, 0, 1, ST_WAIT_LOCK));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 0, 1, ST_STABLE_CHK));
    add(1, 1, 1,  1, mk(1, 1, 0, 0, 0, 0, ST_PLL_RST));
    add(0, 1, 0,  4, mk(0, 1, 0, 0, 0, 0, ST_WAIT_LOCK));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 0, 0, ST_STABLE_CHK));
    add(0, 1, 0,  7, mk(0, 0, 1, 0, 0, 0, ST_RUN));
    // One timeout then a good lock: reaching RUN clears retry_count.
    add(0, 0, 1,  1, mk(1, 1, 0, 0, 0, 0, ST_PLL_RST));
    add(0, 0, 0,  4, mk(0, 1, 0, 0, 0, 0, ST_WAIT_LOCK));
    add(0, 0, 0, 40, mk(1, 1, 0, 0, 1, 0, ST_PLL_RST));
    add(0, 1, 0,  4, mk(0, 1, 0, 0, 1, 0, ST_WAIT_LOCK));
    add(0, 1, 0,  1, mk(0, 1, 0, 0, 1, 0, ST_STABLE_CHK));
    add(0, 1, 0,  7, mk(0, 0, 1, 0, 0, 0, ST_RUN));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].locked, vecs[i].frc,
           vecs[i].n, vecs[i].exp);
    end

    // Repeated lock loss from RUN: lock_loss_count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      sat = (i + 1 > 255) ? 255 : i + 1;
      step($sformatf("loss_drop%0d", i), 0, 0, 0, 3,
           mk(1, 1, 0, 0, 0, sat, ST_PLL_RST));
      step($sformatf("loss_requal%0d", i), 0, 1, 0, 12,
           mk(0, 0, 1, 0, 0, sat, ST_RUN));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
